// File: rtl/allophone_feeder_pkg.sv
// Shared Speech256 definitions: allophone code width, a subset of the
// SP0256 allophone code points, and the feeder handshake state encoding.
package allophone_feeder_pkg;

    localparam int ALLO_W = 6;

    typedef logic [ALLO_W-1:0] allo_t;

    // Pauses
    localparam allo_t PA1 = 6'h00;
    localparam allo_t PA2 = 6'h01;
    localparam allo_t PA3 = 6'h02;
    localparam allo_t PA4 = 6'h03;
    localparam allo_t PA5 = 6'h04;
    // Vowels and consonants (first code page)
    localparam allo_t OY  = 6'h05;
    localparam allo_t AY  = 6'h06;
    localparam allo_t EH  = 6'h07;
    localparam allo_t KK3 = 6'h08;
    localparam allo_t PP  = 6'h09;
    localparam allo_t JH  = 6'h0A;
    localparam allo_t NN1 = 6'h0B;
    localparam allo_t IH  = 6'h0C;
    localparam allo_t TT2 = 6'h0D;
    localparam allo_t RR1 = 6'h0E;
    localparam allo_t AX  = 6'h0F;
    localparam allo_t MM  = 6'h10;
    localparam allo_t TT1 = 6'h11;
    localparam allo_t DH1 = 6'h12;
    localparam allo_t IY  = 6'h13;
    localparam allo_t EY  = 6'h14;
    localparam allo_t DD1 = 6'h15;
    localparam allo_t UW1 = 6'h16;
    localparam allo_t AO  = 6'h17;
    localparam allo_t AA  = 6'h18;
    localparam allo_t YY2 = 6'h19;
    localparam allo_t AE  = 6'h1A;
    localparam allo_t HH1 = 6'h1B;
    localparam allo_t BB1 = 6'h1C;
    localparam allo_t TH  = 6'h1D;
    localparam allo_t UH  = 6'h1E;
    localparam allo_t UW2 = 6'h1F;

    // Handshake states toward the sequencer.
    typedef enum logic [1:0] {
        S_READY = 2'd0,   // waiting for ldq high with a code queued
        S_ACK   = 2'd1,   // strobe issued, waiting for ldq to fall
        S_SPEAK = 2'd2    // sequencer speaking, waiting for ldq to rise
    } feeder_state_e;

    // True for the silence/pause allophones PA1..PA5.
    function automatic logic is_pause(input allo_t code);
        return code <= PA5;
    endfunction

endpackage

// File: rtl/allophone_feeder_if.sv
// Host/sequencer signal bundle for the allophone feeder. The master side is
// the host plus sequencer environment; the slave side is the feeder itself.
interface allophone_feeder_if #(
    parameter int AW = 4
);
    import allophone_feeder_pkg::*;

    allo_t       wr_data;
    logic        wr_stb;
    logic        flush;
    logic        ldq;
    allo_t       data_out;
    logic        data_stb;
    logic        full;
    logic [AW:0] level;
    logic        busy;
    logic        overflow;
    logic        err;

    modport master (
        output wr_data, wr_stb, flush, ldq,
        input  data_out, data_stb, full, level, busy, overflow, err
    );

    modport slave (
        input  wr_data, wr_stb, flush, ldq,
        output data_out, data_stb, full, level, busy, overflow, err
    );

endinterface

// File: rtl/allophone_feeder_allo_fifo.sv
// Show-ahead allophone FIFO built from a register array. Writes are refused
// while full even if a pop happens in the same cycle; flush empties the queue
// and discards any write presented in the same cycle.
module allo_fifo
    import allophone_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req_i,
    input  allo_t       wr_data_i,
    input  logic        rd_en_i,
    input  logic        flush_i,
    output allo_t       head_o,
    output logic [AW:0] level_o,
    output logic        full_o,
    output logic        empty_o,
    output logic        wr_drop_o
);

    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    allo_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;
    logic          wr_acc;
    logic          rd_acc;

    assign full_o    = (level_q == LEVEL_FULL);
    assign empty_o   = (rd_ptr_q == wr_ptr_q) && (level_q == '0);
    assign level_o   = level_q;
    assign head_o    = mem_q[rd_ptr_q];

    // Acceptance uses the pre-edge level, so a same-cycle pop never makes room.
    assign wr_acc    = wr_req_i && !full_o && !flush_i;
    assign rd_acc    = rd_en_i && !empty_o && !flush_i;
    assign wr_drop_o = wr_req_i && full_o && !flush_i;

    // Pointer and occupancy update; flush takes priority over everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer/level registers; contents are simply abandoned on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; no reset needed because level gates every read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/allophone_feeder.sv
// Host-side allophone sender for Speech256. Queues host codes and hands one
// to the sequencer per ldq request using a strobe / ack-by-ldq-fall handshake,
// flagging a sticky error when the sequencer fails to acknowledge in time.
module allophone_feeder
    import allophone_feeder_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input logic               clk,
    input logic               rst,
    allophone_feeder_if.slave bus
);

    localparam int            CW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);

    feeder_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    allo_t         data_out_q, data_out_d;
    logic          data_stb_q, data_stb_d;
    logic          overflow_q, overflow_d;
    logic          err_q, err_d;
    logic          ldq_q;
    logic          pop;

    allo_t         fifo_head;
    logic [AW:0]   fifo_level;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;

    allo_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_req_i  (bus.wr_stb),
        .wr_data_i (bus.wr_data),
        .rd_en_i   (pop),
        .flush_i   (bus.flush),
        .head_o    (fifo_head),
        .level_o   (fifo_level),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .wr_drop_o (fifo_drop)
    );

    assign bus.data_out = data_out_q;
    assign bus.data_stb = data_stb_q;
    assign bus.overflow = overflow_q;
    assign bus.err      = err_q;
    assign bus.level    = fifo_level;
    assign bus.full     = fifo_full;
    // Busy whenever anything is pending or the sequencer is not asking.
    assign bus.busy     = !fifo_empty || (state_q != S_READY) || !ldq_q;

    // Handshake next-state logic, working from the registered ldq.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        data_stb_d = 1'b0;
        err_d      = err_q;
        pop        = 1'b0;
        unique case (state_q)
            S_READY: begin
                // A coincident flush wins over the pop.
                if (ldq_q && !fifo_empty && !bus.flush) begin
                    data_out_d = fifo_head;
                    data_stb_d = 1'b1;
                    pop        = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_ACK;
                end
            end
            S_ACK: begin
                // Only a low ldq ends the ack; a high ldq just runs the timer.
                if (!ldq_q) begin
                    state_d = S_SPEAK;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SPEAK: begin
                if (ldq_q) begin
                    state_d = S_READY;
                end
            end
            default: begin
                state_d = S_READY;
            end
        endcase
    end

    // Overflow is sticky until flush; a flushed write is not a drop.
    always_comb begin
        overflow_d = overflow_q;
        if (bus.flush) begin
            overflow_d = 1'b0;
        end else if (fifo_drop) begin
            overflow_d = 1'b1;
        end
    end

    // State, output and flag registers; ldq is sampled once here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_READY;
            cnt_q      <= '0;
            data_out_q <= '0;
            data_stb_q <= 1'b0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
            ldq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            data_stb_q <= data_stb_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
            ldq_q      <= bus.ldq;
        end
    end

endmodule

// File: tb/tb_allophone_feeder.sv
// Scoreboard bench for allophone_feeder: a DEPTH=16 instance exercised with
// a sequencer-like ldq model, and a DEPTH=4 instance for pointer wrap.
module tb_allophone_feeder;
    import allophone_feeder_pkg::*;

    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int TMO     = 4;
    localparam int N_SPEAK = 20;

    typedef enum int {LDQ_LOW, LDQ_HIGH, LDQ_SEQ} ldq_mode_e;

    logic      clk = 1'b0;
    logic      rst;
    ldq_mode_e ldq_mode = LDQ_LOW;
    int        spk_cnt = 0;
    int        cyc = 0;
    int        n_checks = 0;
    int        n_errors = 0;
    int        stb_count = 0;
    int        last_stb = 0;
    bit        last_valid = 0;
    bit        gap_chk = 0;
    allo_t     exp_q[$];
    allo_t     exp4_q[$];

    always #5 clk = ~clk;

    allophone_feeder_if #(.AW(AW)) bus ();
    allophone_feeder_if #(.AW(2))  bus4 ();

    allophone_feeder #(.DEPTH(DEPTH), .AW(AW), .ACK_TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    allophone_feeder #(.DEPTH(4), .AW(2), .ACK_TIMEOUT(TMO)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input allo_t c, input bit acc);
        bus.wr_data = c;
        bus.wr_stb  = 1'b1;
        if (acc) exp_q.push_back(c);
        tick();
        bus.wr_stb  = 1'b0;
    endtask

    task automatic wr4(input allo_t c);
        bus4.wr_data = c;
        bus4.wr_stb  = 1'b1;
        exp4_q.push_back(c);
        tick();
        bus4.wr_stb  = 1'b0;
    endtask

    task automatic wait_stb(input int which, input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if ((which == 0) ? bus.data_stb : bus4.data_stb) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    always @(posedge clk) cyc++;

    // Sequencer model: ldq falls one cycle after a strobe, rises N_SPEAK later.
    always @(posedge clk) begin
        #1;
        case (ldq_mode)
            LDQ_LOW:  begin bus.ldq = 1'b0; spk_cnt = 0; end
            LDQ_HIGH: begin bus.ldq = 1'b1; spk_cnt = 0; end
            default: begin
                if (spk_cnt != 0) begin
                    spk_cnt--;
                    bus.ldq = (spk_cnt == 0);
                end else if (bus.data_stb) begin
                    spk_cnt = N_SPEAK + 1;
                end else begin
                    bus.ldq = 1'b1;
                end
            end
        endcase
    end

    // Strobe monitor: pops the scoreboard and checks spacing.
    always @(negedge clk) begin
        if (rst) begin
            last_valid = 1'b0;
        end else if (bus.data_stb) begin
            stb_count++;
            $display("[%0d] strobe data_out=0x%02h", cyc, bus.data_out);
            if (last_valid) begin
                check_eq("stb_gap_min", int'((cyc - last_stb) >= 3), 1);
                if (gap_chk) check_eq("stb_gap_21", int'((cyc - last_stb) >= 21), 1);
            end
            check_eq("sb_nonempty", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_eq("data_out", int'(bus.data_out), int'(exp_q.pop_front()));
            last_stb   = cyc;
            last_valid = 1'b1;
        end
    end

    initial begin
        bit    seen;
        int    s0;
        int    i6;
        allo_t z;

        rst = 1'b1;
        bus.wr_data = '0;  bus.wr_stb = 1'b0;  bus.flush = 1'b0;
        bus4.wr_data = '0; bus4.wr_stb = 1'b0; bus4.flush = 1'b0; bus4.ldq = 1'b0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_level",    int'(bus.level),    0);
        check_eq("rst_full",     int'(bus.full),     0);
        check_eq("rst_data_out", int'(bus.data_out), 0);
        check_eq("rst_data_stb", int'(bus.data_stb), 0);
        check_eq("rst_overflow", int'(bus.overflow), 0);
        check_eq("rst_err",      int'(bus.err),      0);
        check_eq("rst_busy",     int'(bus.busy),     1);
        rst = 1'b0;

        // 1: three codes through the sequencer model
        ldq_mode = LDQ_SEQ;
        gap_chk  = 1'b1;
        repeat (3) tick();
        s0 = stb_count;
        wr(6'h2A, 1'b1);
        wr(6'h05, 1'b1);
        wr(6'h3F, 1'b1);
        for (int k = 0; k < 300 && (stb_count - s0) < 3; k++) tick();
        check_eq("t1_strobes", stb_count - s0, 3);
        repeat (40) tick();
        check_eq("t1_level", int'(bus.level), 0);
        check_eq("t1_busy",  int'(bus.busy),  0);
        check_eq("t1_sb_empty", exp_q.size(), 0);
        gap_chk = 1'b0;

        // 2: fill past DEPTH with ldq low, then flush with a coincident write
        ldq_mode = LDQ_LOW;
        repeat (3) tick();
        s0 = stb_count;
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr(allo_t'(i + 1), i < DEPTH);
            if (i == DEPTH - 1) begin
                check_eq("t2_full_at_16", int'(bus.full), 1);
                check_eq("t2_ovf_at_16",  int'(bus.overflow), 0);
            end
        end
        check_eq("t2_level",    int'(bus.level),    DEPTH);
        check_eq("t2_overflow", int'(bus.overflow), 1);
        check_eq("t2_no_stb",   stb_count - s0,     0);
        bus.flush = 1'b1; bus.wr_stb = 1'b1; bus.wr_data = 6'h11;
        tick();
        bus.flush = 1'b0; bus.wr_stb = 1'b0;
        exp_q.delete();
        check_eq("t2_flush_level", int'(bus.level),    0);
        check_eq("t2_flush_ovf",   int'(bus.overflow), 0);
        check_eq("t2_flush_full",  int'(bus.full),     0);

        // 3: full FIFO, write lands on the pop cycle
        for (int i = 0; i < DEPTH; i++) wr(allo_t'(6'h20 + i), 1'b1);
        check_eq("t3_full", int'(bus.full), 1);
        ldq_mode = LDQ_HIGH;
        tick();
        tick();
        ldq_mode = LDQ_LOW;
        bus.wr_stb = 1'b1; bus.wr_data = 6'h3E;
        tick();
        bus.wr_stb = 1'b0;
        check_eq("t3_stb",      int'(bus.data_stb), 1);
        check_eq("t3_level",    int'(bus.level),    DEPTH - 1);
        check_eq("t3_overflow", int'(bus.overflow), 1);
        check_eq("t3_full_off", int'(bus.full),     0);
        repeat (6) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        exp_q.delete();
        check_eq("t3_flush_level", int'(bus.level), 0);
        check_eq("t3_err_clear",   int'(bus.err),   0);
        ldq_mode = LDQ_HIGH;
        repeat (6) tick();

        // 4: ldq stuck high -> ack timeout
        wr(6'h07, 1'b1);
        wr(6'h13, 1'b1);
        wait_stb(0, 10, seen);
        check_eq("t4_stb_seen", int'(seen), 1);
        check_eq("t4_err_at_stb", int'(bus.err), 0);
        for (int k = 1; k < TMO; k++) begin
            tick();
            check_eq("t4_err_early", int'(bus.err), 0);
        end
        tick();
        check_eq("t4_err_set", int'(bus.err),      1);
        check_eq("t4_stb_gap", int'(bus.data_stb), 0);
        tick();
        check_eq("t4_next_stb", int'(bus.data_stb), 1);
        ldq_mode = LDQ_LOW;
        repeat (10) tick();
        check_eq("t4_err_sticky", int'(bus.err),   1);
        check_eq("t4_level",      int'(bus.level), 0);
        check_eq("t4_busy",       int'(bus.busy),  1);

        // 5: reset in S_ACK with codes queued
        for (int i = 0; i < 6; i++) wr(allo_t'(6'h30 + i), 1'b1);
        ldq_mode = LDQ_HIGH;
        wait_stb(0, 10, seen);
        check_eq("t5_stb_seen", int'(seen), 1);
        #2;
        rst = 1'b1;
        ldq_mode = LDQ_LOW;
        exp_q.delete();
        #1;
        check_eq("t5_rst_stb",   int'(bus.data_stb), 0);
        check_eq("t5_rst_level", int'(bus.level),    0);
        check_eq("t5_rst_err",   int'(bus.err),      0);
        check_eq("t5_rst_ovf",   int'(bus.overflow), 0);
        check_eq("t5_rst_dout",  int'(bus.data_out), 0);
        tick();
        tick();
        rst = 1'b0;
        ldq_mode = LDQ_HIGH;
        repeat (3) tick();
        z = EH;
        wr(z, 1'b1);
        wait_stb(0, 10, seen);
        check_eq("t5_new_stb_seen", int'(seen), 1);
        tick();
        check_eq("t5_sb_empty", exp_q.size(), 0);
        ldq_mode = LDQ_LOW;
        repeat (8) tick();

        // 6: pointer wrap on the DEPTH=4 instance, bursts of 1..4 codes
        i6 = 0;
        bus4.ldq = 1'b0;
        repeat (3) tick();
        while (i6 < 40) begin
            int k;
            k = (i6 % 10 == 0) ? 1 : (i6 % 10 == 1) ? 2 : (i6 % 10 == 3) ? 3 : 4;
            for (int j = 0; j < k; j++) begin
                wr4(allo_t'(i6 * 7 + 3));
                i6++;
            end
            bus4.ldq = 1'b1;
            for (int j = 0; j < k; j++) begin
                wait_stb(1, 12, seen);
                check_eq("t6_stb_seen", int'(seen), 1);
                if (seen && exp4_q.size() != 0) begin
                    $display("[%0d] wrap strobe data_out=0x%02h", cyc, bus4.data_out);
                    check_eq("t6_data", int'(bus4.data_out), int'(exp4_q.pop_front()));
                end
                bus4.ldq = 1'b0;
                tick();
                tick();
                bus4.ldq = 1'b1;
            end
            bus4.ldq = 1'b0;
            repeat (3) tick();
        end
        check_eq("t6_overflow", int'(bus4.overflow), 0);
        check_eq("t6_level",    int'(bus4.level),    0);
        check_eq("t6_sb_empty", exp4_q.size(),       0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
